// File: rtl/popcount_accum.sv
// rtl/popcount_accum.sv - per-packet set-bit accumulator with one-entry valid/ready result register
// ACC_SAT_EN defined: accumulator saturates on overflow; undefined: accumulator wraps.
module popcount_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 16,
  parameter int ACC_WIDTH  = 9
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [ACC_WIDTH-1:0]           m_count,
  output logic [$clog2(MAX_WORDS+1)-1:0] m_words,
  output logic                           m_ovf
);

  localparam int PCW = $clog2(DATA_WIDTH) + 1;
  localparam int WW  = $clog2(MAX_WORDS + 1);
  // Sum must hold acc plus the widest popcount without losing the carry.
  localparam int SW  = (ACC_WIDTH + 1 > PCW) ? ACC_WIDTH + 1 : PCW + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc;
  logic [WW-1:0]        wcnt;
  logic                 ovf_sticky;

  logic [PCW-1:0]       pc;
  logic [SW-1:0]        sum;
  logic                 ovf_word;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [WW-1:0]        wcnt_inc;
  logic                 accept;
  logic                 closing;
  logic                 load;

  assign s_ready = resetn && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  always_comb begin
    pc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pc = pc + PCW'(s_data[i]);
    end
  end

  assign sum      = SW'(acc) + SW'(pc);
  assign ovf_word = |sum[SW-1:ACC_WIDTH];
  assign wcnt_inc = wcnt + WW'(1);
  assign closing  = s_last || (wcnt_inc == WW'(MAX_WORDS));

`ifdef ACC_SAT_EN
  assign acc_next = ovf_word ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign acc_next = sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (closing) load = 1'b1;
          else         state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && closing) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      acc        <= '0;
      wcnt       <= '0;
      ovf_sticky <= 1'b0;
      m_valid    <= 1'b0;
      m_count    <= '0;
      m_words    <= '0;
      m_ovf      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (load) begin
        m_valid    <= 1'b1;
        m_count    <= acc_next;
        m_words    <= wcnt_inc;
        m_ovf      <= ovf_sticky | ovf_word;
        acc        <= '0;
        wcnt       <= '0;
        ovf_sticky <= 1'b0;
      end else if (accept) begin
        acc        <= acc_next;
        wcnt       <= wcnt_inc;
        ovf_sticky <= ovf_sticky | ovf_word;
      end
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// tb/tb_popcount_accum.sv - self-checking bench for popcount_accum (default and ACC_WIDTH=4 instances)
module tb_popcount_accum;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid, s_last, m_ready;
  logic [15:0] s_data;
  logic        s_ready, m_valid, m_ovf;
  logic [8:0]  m_count;
  logic [4:0]  m_words;
  logic        s_ready4, m_valid4, m_ovf4;
  logic [3:0]  m_count4;
  logic [4:0]  m_words4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  popcount_accum dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_count(m_count), .m_words(m_words), .m_ovf(m_ovf)
  );

  popcount_accum #(.ACC_WIDTH(4)) dut4 (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready4),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid4), .m_ready(m_ready),
    .m_count(m_count4), .m_words(m_words4), .m_ovf(m_ovf4)
  );

  // Expected 4-bit result from a packet's true total of ones.
  function automatic logic [3:0] exp4(int total);
`ifdef ACC_SAT_EN
    return (total > 15) ? 4'hF : 4'(total);
`else
    return 4'(total % 16);
`endif
  endfunction

  // Drive inputs at the falling edge, then let combinational outputs settle.
  task automatic step(logic v, logic [15:0] d, logic l, logic r);
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; m_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; s_valid = 1'b1; s_data = 16'hFFFF; s_last = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_count !== 9'd0 || m_words !== 5'd0 || m_ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset: s_ready=%b m_valid=%b m_count=%0d m_words=%0d m_ovf=%b, want 0 0 0 0 0",
               s_ready, m_valid, m_count, m_words, m_ovf);
    end
    s_valid = 1'b0; s_last = 1'b0;
    resetn = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: s_ready=%b want 1", s_ready);
    end
  endtask

  task automatic test_basic();
    step(1, 16'd3, 0, 1);
    step(1, 16'd5, 0, 1);
    step(1, 16'd8, 1, 1);
    tests++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_early: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
    step(0, 16'd0, 0, 1);
    tests++;
    if (m_valid !== 1'b1 || m_count !== 9'd5 || m_words !== 5'd3 || m_ovf !== 1'b0) begin
      fails++;
      $display("FAIL basic: m_valid=%b m_count=%0d m_words=%0d m_ovf=%b want 1 5 3 0",
               m_valid, m_count, m_words, m_ovf);
    end
    step(0, 16'd0, 0, 1);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain: m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 16'hFFFF, 1, 1);
    step(1, 16'h0001, 1, 1);
    tests++;
    if (m_valid !== 1'b1 || m_count !== 9'd16 || m_words !== 5'd1 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: m_valid=%b m_count=%0d m_words=%0d s_ready=%b want 1 16 1 1",
               m_valid, m_count, m_words, s_ready);
    end
    step(0, 16'd0, 0, 1);
    tests++;
    if (m_valid !== 1'b1 || m_count !== 9'd1 || m_words !== 5'd1) begin
      fails++;
      $display("FAIL b2b_second: m_valid=%b m_count=%0d m_words=%0d want 1 1 1", m_valid, m_count, m_words);
    end
  endtask

  task automatic test_stall();
    step(0, 16'd0, 0, 1);
    step(1, 16'h00F0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 16'($urandom), 1, 0);
      tests++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_count !== 9'd4 || m_words !== 5'd1) begin
        fails++;
        $display("FAIL stall[%0d]: s_ready=%b m_valid=%b m_count=%0d m_words=%0d want 0 1 4 1",
                 i, s_ready, m_valid, m_count, m_words);
      end
    end
    step(0, 16'd0, 0, 1);
    tests++;
    if (s_ready !== 1'b1 || m_valid !== 1'b1 || m_count !== 9'd4) begin
      fails++;
      $display("FAIL stall_release: s_ready=%b m_valid=%b m_count=%0d want 1 1 4", s_ready, m_valid, m_count);
    end
    step(0, 16'd0, 0, 1);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_drain: m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_max_words();
    for (int i = 0; i < 16; i++) step(1, 16'h0001, 0, 1);
    step(1, 16'h0003, 0, 1);
    tests++;
    if (m_valid !== 1'b1 || m_count !== 9'd16 || m_words !== 5'd16) begin
      fails++;
      $display("FAIL max_words: m_valid=%b m_count=%0d m_words=%0d want 1 16 16", m_valid, m_count, m_words);
    end
    step(1, 16'h0001, 1, 1);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL max_words_gap: m_valid=%b want 0", m_valid);
    end
    step(0, 16'd0, 0, 1);
    tests++;
    if (m_valid !== 1'b1 || m_count !== 9'd3 || m_words !== 5'd2) begin
      fails++;
      $display("FAIL max_words_next: m_valid=%b m_count=%0d m_words=%0d want 1 3 2", m_valid, m_count, m_words);
    end
  endtask

  task automatic test_overflow();
    step(0, 16'd0, 0, 1);
    step(1, 16'hFFFF, 0, 1);
    step(1, 16'h0003, 1, 1);
    step(0, 16'd0, 0, 1);
    tests++;
    if (m_valid4 !== 1'b1 || m_count4 !== exp4(18) || m_words4 !== 5'd2 || m_ovf4 !== 1'b1) begin
      fails++;
      $display("FAIL ovf4: m_valid=%b m_count=%0d m_words=%0d m_ovf=%b want 1 %0d 2 1",
               m_valid4, m_count4, m_words4, m_ovf4, exp4(18));
    end
    tests++;
    if (m_count !== 9'd18 || m_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf9: m_count=%0d m_ovf=%b want 18 0", m_count, m_ovf);
    end
  endtask

  task automatic test_mid_reset();
    step(0, 16'd0, 0, 1);
    step(1, 16'h00FF, 0, 1);
    step(1, 16'h000F, 0, 1);
    @(negedge clk);
    resetn = 1'b0; s_valid = 1'b0;
    #1;
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_ready: s_ready=%b want 0", s_ready);
    end
    @(negedge clk);
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_count !== 9'd0 || m_words !== 5'd0 || m_ovf !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: m_valid=%b m_count=%0d m_words=%0d m_ovf=%b want 0 0 0 0",
               m_valid, m_count, m_words, m_ovf);
    end
    resetn = 1'b1;
    step(1, 16'h0001, 1, 1);
    step(0, 16'd0, 0, 1);
    tests++;
    if (m_valid !== 1'b1 || m_count !== 9'd1 || m_words !== 5'd1 || m_ovf !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_packet: m_valid=%b m_count=%0d m_words=%0d m_ovf=%b want 1 1 1 0",
               m_valid, m_count, m_words, m_ovf);
    end
  endtask

  task automatic test_random();
    int tot_q[$];
    int wrd_q[$];
    int cur_tot;
    int cur_wrd;
    logic exp_valid;
    do_reset();
    cur_tot = 0;
    cur_wrd = 0;
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 4) != 0, 16'($urandom), ($urandom % 6) == 0, ($urandom % 3) != 0);
      exp_valid = (tot_q.size() != 0);
      tests++;
      if (m_valid !== exp_valid || s_ready !== (!exp_valid || m_ready) || s_ready4 !== s_ready) begin
        fails++;
        $display("FAIL rand_hs[%0d]: m_valid=%b s_ready=%b s_ready4=%b want %b %b",
                 c, m_valid, s_ready, s_ready4, exp_valid, !exp_valid || m_ready);
      end
      if (exp_valid && m_ready) begin
        tests++;
        if (m_count !== 9'(tot_q[0]) || m_words !== 5'(wrd_q[0]) || m_ovf !== 1'b0 ||
            m_count4 !== exp4(tot_q[0]) || m_words4 !== 5'(wrd_q[0]) || m_ovf4 !== (tot_q[0] >= 16)) begin
          fails++;
          $display("FAIL rand_res[%0d]: count=%0d words=%0d ovf=%b count4=%0d words4=%0d ovf4=%b want %0d %0d 0 %0d %0d %b",
                   c, m_count, m_words, m_ovf, m_count4, m_words4, m_ovf4,
                   tot_q[0], wrd_q[0], exp4(tot_q[0]), wrd_q[0], tot_q[0] >= 16);
        end
        void'(tot_q.pop_front());
        void'(wrd_q.pop_front());
      end
      if (s_valid && (!exp_valid || m_ready)) begin
        cur_tot += $countones(s_data);
        cur_wrd++;
        if (s_last || cur_wrd == 16) begin
          tot_q.push_back(cur_tot);
          wrd_q.push_back(cur_wrd);
          cur_tot = 0;
          cur_wrd = 0;
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_max_words();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
